// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single data-memory port between the core MEM stage and a debug/loader port.
// The core wins conflicts until a waiting debug request has lost MAX_WAIT times; dbg_lock holds the port for bursts.
module dmem_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9,
  parameter int MAX_WAIT   = 8,
  parameter int CNT_W      = 16,
  localparam int WAIT_W    = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_rd,
  input  logic                  cpu_wr,
  input  logic [DM_ADDRESS-1:0] cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  input  logic [2:0]            cpu_func3,
  output logic [DATA_W-1:0]     cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  dbg_valid,
  input  logic                  dbg_we,
  input  logic [DM_ADDRESS-1:0] dbg_addr,
  input  logic [DATA_W-1:0]     dbg_wdata,
  input  logic [2:0]            dbg_func3,
  input  logic                  dbg_lock,
  output logic                  dbg_ready,
  output logic [DATA_W-1:0]     dbg_rdata,
  output logic                  dbg_rvalid,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [2:0]            mem_func3,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic                  fsm_state,
  output logic [WAIT_W-1:0]     wait_cnt
);

  typedef enum logic {S_CPU = 1'b0, S_DBG = 1'b1} state_t;

  state_t state_q, state_d;
  logic   cpu_req;
  logic   force_dbg;
  logic   dbg_owner;
  logic   fire;

  assign cpu_req   = cpu_rd | cpu_wr;
  assign force_dbg = dbg_valid & (wait_cnt >= WAIT_W'(MAX_WAIT));
  assign fsm_state = state_q;

  always_comb begin
    state_d   = state_q;
    dbg_owner = 1'b0;
    case (state_q)
      S_CPU: begin
        dbg_owner = force_dbg | ~cpu_req;
        if (dbg_owner & dbg_valid & dbg_lock) state_d = S_DBG;
      end
      S_DBG: begin
        dbg_owner = 1'b1;
        if (!dbg_lock) state_d = S_CPU;
      end
      default: state_d = S_CPU;
    endcase
  end

  // Debug handshake: a transfer happens in any cycle where dbg_valid and dbg_ready are both 1;
  // the requester keeps dbg_valid and its payload stable until then. Nothing is granted in reset.
  assign dbg_ready = reset & dbg_owner;
  assign fire      = dbg_valid & dbg_ready;
  assign cpu_stall = reset & dbg_owner & cpu_req;

  assign mem_rd    = reset & (dbg_owner ? (dbg_valid & ~dbg_we) : cpu_rd);
  assign mem_wr    = reset & (dbg_owner ? (dbg_valid &  dbg_we) : cpu_wr);
  assign mem_addr  = dbg_owner ? dbg_addr  : cpu_addr;
  assign mem_wdata = dbg_owner ? dbg_wdata : cpu_wdata;
  assign mem_func3 = dbg_owner ? dbg_func3 : cpu_func3;
  assign cpu_rdata = mem_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_CPU;
      wait_cnt   <= '0;
      dbg_rvalid <= 1'b0;
      dbg_rdata  <= '0;
      stall_cnt  <= '0;
    end else begin
      state_q    <= state_d;
      dbg_rvalid <= fire & ~dbg_we;
      if (fire & ~dbg_we) dbg_rdata <= mem_rdata;
      // Losses only accumulate while a request is actually waiting.
      if (fire || !dbg_valid)
        wait_cnt <= '0;
      else if (wait_cnt < WAIT_W'(MAX_WAIT))
        wait_cnt <= wait_cnt + 1'b1;
      if (cpu_stall && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios plus randomized traffic against a rule-level model.
// A second instance built with MAX_WAIT=0 and a narrow stall counter covers strict debug priority and saturation.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_rd, cpu_wr, dbg_valid, dbg_we, dbg_lock;
  logic [8:0]  cpu_addr, dbg_addr;
  logic [31:0] cpu_wdata, dbg_wdata, mem_rdata;
  logic [2:0]  cpu_func3, dbg_func3;

  logic [31:0] cpu_rdata, dbg_rdata, mem_wdata;
  logic        cpu_stall, dbg_ready, dbg_rvalid, mem_rd, mem_wr, fsm_state;
  logic [8:0]  mem_addr;
  logic [2:0]  mem_func3;
  logic [15:0] stall_cnt;
  logic [3:0]  wait_cnt;

  logic [31:0] z_cpu_rdata, z_dbg_rdata, z_mem_wdata;
  logic        z_cpu_stall, z_dbg_ready, z_dbg_rvalid, z_mem_rd, z_mem_wr, z_fsm_state;
  logic [8:0]  z_mem_addr;
  logic [2:0]  z_mem_func3;
  logic [3:0]  z_stall_cnt;
  logic [0:0]  z_wait_cnt;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.DATA_W(32), .DM_ADDRESS(9), .MAX_WAIT(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_func3(cpu_func3), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_valid(dbg_valid), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_func3(dbg_func3), .dbg_lock(dbg_lock), .dbg_ready(dbg_ready), .dbg_rdata(dbg_rdata),
    .dbg_rvalid(dbg_rvalid), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_func3(mem_func3), .mem_rdata(mem_rdata), .stall_cnt(stall_cnt),
    .fsm_state(fsm_state), .wait_cnt(wait_cnt)
  );

  dmem_port_arbiter #(.DATA_W(32), .DM_ADDRESS(9), .MAX_WAIT(0), .CNT_W(4)) dut_z (
    .clk(clk), .reset(reset), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_func3(cpu_func3), .cpu_rdata(z_cpu_rdata), .cpu_stall(z_cpu_stall),
    .dbg_valid(dbg_valid), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_func3(dbg_func3), .dbg_lock(dbg_lock), .dbg_ready(z_dbg_ready), .dbg_rdata(z_dbg_rdata),
    .dbg_rvalid(z_dbg_rvalid), .mem_rd(z_mem_rd), .mem_wr(z_mem_wr), .mem_addr(z_mem_addr),
    .mem_wdata(z_mem_wdata), .mem_func3(z_mem_func3), .mem_rdata(mem_rdata), .stall_cnt(z_stall_cnt),
    .fsm_state(z_fsm_state), .wait_cnt(z_wait_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_func3 = 3'd2;
    dbg_valid = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0; dbg_func3 = 3'd2;
    dbg_lock = 1'b0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    tick();
    cpu_rd = 1'b1; dbg_valid = 1'b1;
    #1;
    total++;
    if ({mem_rd, mem_wr, dbg_ready, cpu_stall, dbg_rvalid, fsm_state} !== 6'b0) $display("FAIL reset_ctrl got=%b exp=000000", {mem_rd, mem_wr, dbg_ready, cpu_stall, dbg_rvalid, fsm_state});
    else passed++;
    total++;
    if ({stall_cnt, wait_cnt, dbg_rdata} !== 52'd0) $display("FAIL reset_regs got=%h/%h/%h exp=0", stall_cnt, wait_cnt, dbg_rdata);
    else passed++;
    tick();
    reset = 1'b1;
    idle_inputs();
    tick();
  endtask

  task automatic test_cpu_read();
    idle_inputs();
    cpu_rd = 1'b1; cpu_addr = 9'h010; mem_rdata = 32'hDEADBEEF;
    #1;
    total++;
    if ({mem_rd, mem_wr, cpu_stall, dbg_ready} !== 4'b1000 || mem_addr !== 9'h010) $display("FAIL cpu_read_ctrl got=%b addr=%h exp=1000 addr=010", {mem_rd, mem_wr, cpu_stall, dbg_ready}, mem_addr);
    else passed++;
    total++;
    if (cpu_rdata !== 32'hDEADBEEF) $display("FAIL cpu_read_data got=%h exp=deadbeef", cpu_rdata);
    else passed++;
    tick();
    idle_inputs();
  endtask

  task automatic test_dbg_write_read();
    idle_inputs();
    dbg_valid = 1'b1; dbg_we = 1'b1; dbg_addr = 9'h020; dbg_wdata = 32'h12345678; dbg_func3 = 3'd2;
    #1;
    total++;
    if ({dbg_ready, mem_wr, mem_rd, cpu_stall} !== 4'b1100 || mem_addr !== 9'h020 || mem_wdata !== 32'h12345678 || mem_func3 !== 3'd2)
      $display("FAIL dbg_write got=%b addr=%h data=%h f3=%0d exp=1100 addr=020 data=12345678 f3=2", {dbg_ready, mem_wr, mem_rd, cpu_stall}, mem_addr, mem_wdata, mem_func3);
    else passed++;
    tick();
    dbg_we = 1'b0; mem_rdata = 32'h12345678;
    #1;
    total++;
    if ({dbg_ready, mem_rd, mem_wr, dbg_rvalid} !== 4'b1100) $display("FAIL dbg_read_issue got=%b exp=1100", {dbg_ready, mem_rd, mem_wr, dbg_rvalid});
    else passed++;
    tick();
    dbg_valid = 1'b0; mem_rdata = 32'h0BAD0BAD;
    #1;
    total++;
    if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'h12345678) $display("FAIL dbg_read_resp got=%b/%h exp=1/12345678", dbg_rvalid, dbg_rdata);
    else passed++;
    tick();
    #1;
    total++;
    if (dbg_rvalid !== 1'b0 || dbg_rdata !== 32'h12345678) $display("FAIL dbg_rvalid_pulse got=%b/%h exp=0/12345678", dbg_rvalid, dbg_rdata);
    else passed++;
    idle_inputs();
  endtask

  task automatic test_starvation();
    do_reset();
    cpu_rd = 1'b1; cpu_addr = 9'h040;
    dbg_valid = 1'b1; dbg_we = 1'b1; dbg_addr = 9'h044; dbg_wdata = 32'h55AA55AA;
    for (int i = 0; i < 8; i++) begin
      #1;
      total++;
      if ({dbg_ready, cpu_stall, mem_rd} !== 3'b001 || mem_addr !== 9'h040 || wait_cnt !== 4'(i))
        $display("FAIL starve_lose%0d got=%b addr=%h wait=%0d exp=001 addr=040 wait=%0d", i, {dbg_ready, cpu_stall, mem_rd}, mem_addr, wait_cnt, i);
      else passed++;
      tick();
    end
    #1;
    total++;
    if ({dbg_ready, cpu_stall, mem_wr, mem_rd} !== 4'b1110 || mem_addr !== 9'h044 || wait_cnt !== 4'd8)
      $display("FAIL starve_force got=%b addr=%h wait=%0d exp=1110 addr=044 wait=8", {dbg_ready, cpu_stall, mem_wr, mem_rd}, mem_addr, wait_cnt);
    else passed++;
    tick();
    dbg_valid = 1'b0;
    #1;
    total++;
    if (wait_cnt !== 4'd0 || stall_cnt !== 16'd1 || cpu_stall !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 9'h040)
      $display("FAIL starve_after got=wait%0d cnt%0d stall%b rd%b addr%h exp=wait0 cnt1 stall0 rd1 addr040", wait_cnt, stall_cnt, cpu_stall, mem_rd, mem_addr);
    else passed++;
    tick();
    idle_inputs();
  endtask

  task automatic test_lock_burst();
    do_reset();
    cpu_wr = 1'b1; cpu_addr = 9'h080; cpu_wdata = 32'h0000AAAA;
    dbg_valid = 1'b1; dbg_we = 1'b1; dbg_lock = 1'b1; dbg_addr = 9'h000; dbg_wdata = 32'hD0;
    for (int i = 0; i < 8; i++) tick();
    for (int k = 0; k < 4; k++) begin
      dbg_addr = 9'(4 * k); dbg_wdata = 32'(32'hD0 + k);
      #1;
      total++;
      if ({dbg_ready, cpu_stall, mem_wr, mem_rd} !== 4'b1110 || mem_addr !== 9'(4 * k) || mem_wdata !== 32'(32'hD0 + k) || fsm_state !== (k != 0))
        $display("FAIL burst_wr%0d got=%b addr=%h data=%h st=%b", k, {dbg_ready, cpu_stall, mem_wr, mem_rd}, mem_addr, mem_wdata, fsm_state);
      else passed++;
      tick();
    end
    dbg_valid = 1'b0; dbg_lock = 1'b0;
    #1;
    total++;
    if ({dbg_ready, cpu_stall, mem_wr, mem_rd, fsm_state} !== 5'b11001) $display("FAIL burst_release got=%b exp=11001", {dbg_ready, cpu_stall, mem_wr, mem_rd, fsm_state});
    else passed++;
    tick();
    #1;
    total++;
    if ({fsm_state, cpu_stall, mem_wr, dbg_ready} !== 4'b0010 || mem_addr !== 9'h080 || mem_wdata !== 32'h0000AAAA || stall_cnt !== 16'd5)
      $display("FAIL burst_core_resume got=%b addr=%h data=%h cnt=%0d exp=0010 addr=080 data=0000aaaa cnt=5", {fsm_state, cpu_stall, mem_wr, dbg_ready}, mem_addr, mem_wdata, stall_cnt);
    else passed++;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid_lock();
    idle_inputs();
    dbg_valid = 1'b1; dbg_we = 1'b0; dbg_lock = 1'b1; dbg_addr = 9'h020; mem_rdata = 32'hCAFEF00D;
    tick();
    cpu_rd = 1'b1; cpu_addr = 9'h050;
    #1;
    total++;
    if ({fsm_state, dbg_rvalid, cpu_stall} !== 3'b111) $display("FAIL midlock_setup got=%b exp=111", {fsm_state, dbg_rvalid, cpu_stall});
    else passed++;
    reset = 1'b0;
    #1;
    total++;
    if ({mem_rd, mem_wr, cpu_stall, dbg_ready, dbg_rvalid, fsm_state} !== 6'b0) $display("FAIL midlock_reset got=%b exp=000000", {mem_rd, mem_wr, cpu_stall, dbg_ready, dbg_rvalid, fsm_state});
    else passed++;
    tick();
    reset = 1'b1; dbg_lock = 1'b0;
    #1;
    total++;
    if ({fsm_state, mem_rd, dbg_ready, cpu_stall} !== 4'b0100 || mem_addr !== 9'h050) $display("FAIL midlock_core got=%b addr=%h exp=0100 addr=050", {fsm_state, mem_rd, dbg_ready, cpu_stall}, mem_addr);
    else passed++;
    tick();
    cpu_rd = 1'b0;
    #1;
    total++;
    if ({dbg_ready, mem_rd} !== 2'b11 || mem_addr !== 9'h020) $display("FAIL midlock_dbg got=%b addr=%h exp=11 addr=020", {dbg_ready, mem_rd}, mem_addr);
    else passed++;
    tick();
    idle_inputs();
  endtask

  task automatic test_random();
    bit m_locked = 1'b0;
    int m_wait = 0;
    bit m_rvalid = 1'b0;
    logic [31:0] m_rdata = '0;
    int m_stall = 0;
    bit hold_cpu = 1'b0;
    bit hold_dbg = 1'b0;
    bit e_dbg, e_stall, e_rd, e_wr, fire;
    logic [8:0] e_addr;
    logic [31:0] e_wdata;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (!hold_cpu) begin
        cpu_rd = ($urandom_range(0, 99) < 45);
        cpu_wr = !cpu_rd && ($urandom_range(0, 99) < 30);
        cpu_addr = 9'($urandom); cpu_wdata = $urandom; cpu_func3 = 3'($urandom_range(0, 7));
      end
      if (!hold_dbg) begin
        dbg_valid = ($urandom_range(0, 99) < 50);
        dbg_we = 1'($urandom_range(0, 1));
        dbg_addr = 9'($urandom); dbg_wdata = $urandom; dbg_func3 = 3'($urandom_range(0, 7));
      end
      dbg_lock = ($urandom_range(0, 99) < 35);
      mem_rdata = $urandom;
      // Debug gets the port when locked, when it has waited long enough, or when the core is idle.
      e_dbg   = m_locked || (dbg_valid && m_wait >= 8) || !(cpu_rd || cpu_wr);
      e_stall = e_dbg && (cpu_rd || cpu_wr);
      e_rd    = e_dbg ? (dbg_valid && !dbg_we) : cpu_rd;
      e_wr    = e_dbg ? (dbg_valid && dbg_we) : cpu_wr;
      e_addr  = e_dbg ? dbg_addr : cpu_addr;
      e_wdata = e_dbg ? dbg_wdata : cpu_wdata;
      #1;
      total++;
      if ({dbg_ready, cpu_stall, mem_rd, mem_wr} !== {e_dbg, e_stall, e_rd, e_wr})
        $display("FAIL rand_ctrl cyc=%0d got=%b exp=%b", c, {dbg_ready, cpu_stall, mem_rd, mem_wr}, {e_dbg, e_stall, e_rd, e_wr});
      else passed++;
      total++;
      if (mem_addr !== e_addr || mem_wdata !== e_wdata || cpu_rdata !== mem_rdata)
        $display("FAIL rand_data cyc=%0d got=%h/%h/%h exp=%h/%h/%h", c, mem_addr, mem_wdata, cpu_rdata, e_addr, e_wdata, mem_rdata);
      else passed++;
      total++;
      if (dbg_rvalid !== m_rvalid || dbg_rdata !== m_rdata || stall_cnt !== 16'(m_stall) || wait_cnt !== 4'(m_wait))
        $display("FAIL rand_regs cyc=%0d got=%b/%h/%0d/%0d exp=%b/%h/%0d/%0d", c, dbg_rvalid, dbg_rdata, stall_cnt, wait_cnt, m_rvalid, m_rdata, m_stall, m_wait);
      else passed++;
      fire = dbg_valid && e_dbg;
      if (m_locked) m_locked = dbg_lock;
      else if (fire && dbg_lock) m_locked = 1'b1;
      if (fire || !dbg_valid) m_wait = 0;
      else if (m_wait < 8) m_wait++;
      m_rvalid = fire && !dbg_we;
      if (m_rvalid) m_rdata = mem_rdata;
      if (e_stall && m_stall < 65535) m_stall++;
      hold_cpu = e_stall;
      hold_dbg = dbg_valid && !fire;
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_max_wait0();
    do_reset();
    cpu_rd = 1'b1; cpu_addr = 9'h030;
    dbg_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 9'h034;
    for (int i = 0; i < 20; i++) begin
      #1;
      total++;
      if ({z_dbg_ready, z_cpu_stall, z_mem_rd} !== 3'b111 || z_mem_addr !== 9'h034 || z_stall_cnt !== 4'((i > 15) ? 15 : i))
        $display("FAIL mw0_cyc%0d got=%b addr=%h cnt=%0d exp=111 addr=034 cnt=%0d", i, {z_dbg_ready, z_cpu_stall, z_mem_rd}, z_mem_addr, z_stall_cnt, (i > 15) ? 15 : i);
      else passed++;
      tick();
    end
    #1;
    total++;
    if (z_stall_cnt !== 4'hF) $display("FAIL mw0_saturate got=%h exp=f", z_stall_cnt);
    else passed++;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_cpu_read();
    test_dbg_write_read();
    test_starvation();
    test_lock_burst();
    test_reset_mid_lock();
    test_random();
    test_max_wait0();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
